// File: rtl/core_mem_arbiter_if.sv
// Bus bundle for core_mem_arbiter: fetch requester, data requester and the
// single-port memory side, plus the sticky bus-error flag.
// slave  : the arbiter's view (serves requesters, drives the memory).
// master : the environment's view (requesters and memory model).
interface core_mem_arbiter_if #(
    parameter int unsigned AWIDTH = 32,
    parameter int unsigned DWIDTH = 32
);
    // Instruction fetch side
    logic                  IF_Req;
    logic [AWIDTH-1:0]     IF_Addr;
    logic                  IF_Ack;
    logic                  IF_Rvalid;
    logic [DWIDTH-1:0]     IF_Rdata;

    // Data load/store side
    logic                  D_Req;
    logic                  D_Rd;
    logic [AWIDTH-1:0]     D_Addr;
    logic [DWIDTH-1:0]     D_Wdata;
    logic [DWIDTH/8-1:0]   D_Wstrb;
    logic                  D_Ack;
    logic                  D_Rvalid;
    logic [DWIDTH-1:0]     D_Rdata;

    // Memory side
    logic                  Mem_Req;
    logic                  Mem_Rd;
    logic [AWIDTH-1:0]     Mem_Addr;
    logic [DWIDTH-1:0]     Mem_Wdata;
    logic [DWIDTH/8-1:0]   Mem_Wstrb;
    logic                  Mem_Ready;
    logic                  Mem_Rvalid;
    logic [DWIDTH-1:0]     Mem_Rdata;

    logic                  Bus_Error;

    modport slave (
        input  IF_Req, IF_Addr,
        output IF_Ack, IF_Rvalid, IF_Rdata,
        input  D_Req, D_Rd, D_Addr, D_Wdata, D_Wstrb,
        output D_Ack, D_Rvalid, D_Rdata,
        output Mem_Req, Mem_Rd, Mem_Addr, Mem_Wdata, Mem_Wstrb,
        input  Mem_Ready, Mem_Rvalid, Mem_Rdata,
        output Bus_Error
    );

    modport master (
        output IF_Req, IF_Addr,
        input  IF_Ack, IF_Rvalid, IF_Rdata,
        output D_Req, D_Rd, D_Addr, D_Wdata, D_Wstrb,
        input  D_Ack, D_Rvalid, D_Rdata,
        input  Mem_Req, Mem_Rd, Mem_Addr, Mem_Wdata, Mem_Wstrb,
        output Mem_Ready, Mem_Rvalid, Mem_Rdata,
        input  Bus_Error
    );
endinterface

// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter: shares one single-port memory between instruction fetch
// and data load/store. One transaction outstanding at a time; a read that
// gets no Mem_Rvalid within TIMEOUT cycles sets the sticky Bus_Error.
// Optional: define ARB_ROUND_ROBIN_EN for round-robin grant on contention
// (default build is fixed data-over-fetch priority).
module core_mem_arbiter #(
    parameter int unsigned AWIDTH  = 32,
    parameter int unsigned DWIDTH  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                      Clk_Core,
    input  logic                      Rst_Core_N,
    core_mem_arbiter_if.slave         bus
);

    localparam int unsigned SWIDTH = DWIDTH / 8;
    localparam int unsigned CWIDTH = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CWIDTH-1:0] TimeoutVal = CWIDTH'(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

    state_e              state_q;
    logic                owner_q;   // 1 = data port, 0 = fetch port
    logic                rd_q;
    logic [AWIDTH-1:0]   addr_q;
    logic [DWIDTH-1:0]   wdata_q;
    logic [SWIDTH-1:0]   wstrb_q;
    logic [CWIDTH-1:0]   cnt_q;
    logic [CWIDTH-1:0]   cnt_inc;
    logic                if_rvalid_q;
    logic                d_rvalid_q;
    logic [DWIDTH-1:0]   if_rdata_q;
    logic [DWIDTH-1:0]   d_rdata_q;
    logic                bus_error_q;
    logic                grant_data;
    logic                timeout_hit;
`ifdef ARB_ROUND_ROBIN_EN
    logic                last_grant_q;  // 1 = data was granted last
`endif

    // Pick the winner of the IDLE-cycle arbitration.
    always_comb begin
        grant_data = bus.D_Req;
`ifdef ARB_ROUND_ROBIN_EN
        if (bus.D_Req && bus.IF_Req) begin
            grant_data = ~last_grant_q;
        end
`endif
    end

    // Response-wait counter increment and timeout detection.
    always_comb begin
        cnt_inc     = cnt_q + 1'b1;
        timeout_hit = (TIMEOUT != 0) && (cnt_inc == TimeoutVal);
    end

    // Arbiter FSM with latched request fields and registered responses.
    always_ff @(posedge Clk_Core or negedge Rst_Core_N) begin
        if (!Rst_Core_N) begin
            state_q      <= StIdle;
            owner_q      <= 1'b1;
            rd_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            cnt_q        <= '0;
            if_rvalid_q  <= 1'b0;
            d_rvalid_q   <= 1'b0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
            bus_error_q  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.IF_Req || bus.D_Req) begin
                        owner_q <= grant_data;
                        if (grant_data) begin
                            rd_q    <= bus.D_Rd;
                            addr_q  <= bus.D_Addr;
                            wdata_q <= bus.D_Wdata;
                            // Reads never carry byte enables to memory.
                            wstrb_q <= bus.D_Rd ? '0 : bus.D_Wstrb;
                        end else begin
                            rd_q    <= 1'b1;
                            addr_q  <= bus.IF_Addr;
                            wdata_q <= '0;
                            wstrb_q <= '0;
                        end
`ifdef ARB_ROUND_ROBIN_EN
                        last_grant_q <= grant_data;
`endif
                        state_q <= StReq;
                    end
                end
                StReq: begin
                    if (bus.Mem_Ready) begin
                        cnt_q   <= '0;
                        state_q <= rd_q ? StResp : StIdle;
                    end
                end
                StResp: begin
                    if (bus.Mem_Rvalid) begin
                        if (owner_q) begin
                            d_rvalid_q <= 1'b1;
                            d_rdata_q  <= bus.Mem_Rdata;
                        end else begin
                            if_rvalid_q <= 1'b1;
                            if_rdata_q  <= bus.Mem_Rdata;
                        end
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_inc;
                        if (timeout_hit) begin
                            // Give the requester a zero response so it never stalls.
                            bus_error_q <= 1'b1;
                            if (owner_q) begin
                                d_rvalid_q <= 1'b1;
                                d_rdata_q  <= '0;
                            end else begin
                                if_rvalid_q <= 1'b1;
                                if_rdata_q  <= '0;
                            end
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Memory-side drive and same-cycle acknowledge on acceptance.
    assign bus.Mem_Req   = (state_q == StReq);
    assign bus.Mem_Rd    = rd_q;
    assign bus.Mem_Addr  = addr_q;
    assign bus.Mem_Wdata = wdata_q;
    assign bus.Mem_Wstrb = wstrb_q;

    assign bus.IF_Ack    = (state_q == StReq) && bus.Mem_Ready && !owner_q;
    assign bus.D_Ack     = (state_q == StReq) && bus.Mem_Ready && owner_q;
    assign bus.IF_Rvalid = if_rvalid_q;
    assign bus.IF_Rdata  = if_rdata_q;
    assign bus.D_Rvalid  = d_rvalid_q;
    assign bus.D_Rdata   = d_rdata_q;
    assign bus.Bus_Error = bus_error_q;

endmodule
